// File: rtl/tohost_monitor.sv
// Harness-side tohost endpoint: decodes exit/putchar requests, acknowledges on fromhost,
// buffers console bytes and drives sticky pass/fail status with a no-progress watchdog.
module tohost_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int WATCHDOG_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tohost_valid,
  output logic                  tohost_ready,
  input  logic [63:0]           tohost_data,
  output logic                  fromhost_valid,
  input  logic                  fromhost_ready,
  output logic [63:0]           fromhost_data,
  output logic                  cons_valid,
  input  logic                  cons_ready,
  output logic [7:0]            cons_data,
  input  logic                  activity,
  input  logic [WATCHDOG_W-1:0] watchdog_limit,
  output logic                  io_success,
  output logic                  io_failure,
  output logic [31:0]           exit_code
);

  localparam int          PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [63:0] ACK_WORD     = {8'd1, 8'd1, 48'd0};
  localparam logic [31:0] CODE_SYSCALL = 32'hFFFF_FFFE;
  localparam logic [31:0] CODE_BAD     = 32'hFFFF_FFFF;
  localparam logic [31:0] CODE_WDOG    = 32'hDEAD_0001;

  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;

  state_t                state;
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [WATCHDOG_W-1:0] wdog_cnt;
  logic                  fifo_full, fifo_empty, accept, push, pop, wdog_expire;
  logic [7:0]            dev, cmd;
  logic [47:0]           payload;
  logic [31:0]           code;
  logic                  unused_payload_hi;

  assign dev               = tohost_data[63:56];
  assign cmd               = tohost_data[55:48];
  assign payload           = tohost_data[47:0];
  assign code              = payload[32:1];
  assign unused_payload_hi = ^payload[47:33];

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign tohost_ready = (state == IDLE) && !fifo_full;
  assign accept       = tohost_valid && tohost_ready;
  assign push         = accept && (dev == 8'd1) && (cmd == 8'd1);
  assign cons_valid   = !fifo_empty;
  assign pop          = cons_valid && cons_ready;
  assign cons_data    = cons_valid ? fifo_mem[rd_ptr[PTR_W-1:0]] : 8'd0;

  assign wdog_expire = (state != DONE) && (watchdog_limit != '0) &&
                       (wdog_cnt == watchdog_limit) && !activity;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= payload[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
    end else if (activity || accept) begin
      wdog_cnt <= '0;
    end else if (!(&wdog_cnt)) begin
      wdog_cnt <= wdog_cnt + WATCHDOG_W'(1);
    end
  end

  // An accepted word is decoded ahead of watchdog expiry in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      io_success     <= 1'b0;
      io_failure     <= 1'b0;
      exit_code      <= 32'd0;
      fromhost_valid <= 1'b0;
      fromhost_data  <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dev == 8'd0) begin
              if (payload[0]) begin
                if (code == 32'd0) io_success <= 1'b1;
                else               io_failure <= 1'b1;
                exit_code <= code;
              end else begin
                io_failure <= 1'b1;
                exit_code  <= CODE_SYSCALL;
              end
              state <= DONE;
            end else if (push) begin
              fromhost_valid <= 1'b1;
              fromhost_data  <= ACK_WORD;
              state          <= ACK;
            end else begin
              io_failure <= 1'b1;
              exit_code  <= CODE_BAD;
              state      <= DONE;
            end
          end else if (wdog_expire) begin
            io_failure <= 1'b1;
            exit_code  <= CODE_WDOG;
            state      <= DONE;
          end
        end
        ACK: begin
          if (wdog_expire) begin
            fromhost_valid <= 1'b0;
            io_failure     <= 1'b1;
            exit_code      <= CODE_WDOG;
            state          <= DONE;
          end else if (fromhost_ready) begin
            fromhost_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        DONE: begin
          fromhost_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
